// File: rtl/bcd_tick_counter_if.sv
// bcd_tick_counter_if: control/status bundle for bcd_tick_counter.
// Ports: EN, UP, LOAD, LOAD_VAL (master->slave); VAL, TICK, WRAP, ZERO (slave->master).
interface bcd_tick_counter_if #(
    parameter int DIGITS = 4
);
    logic                  EN;
    logic                  UP;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic [4*DIGITS-1:0]   VAL;
    logic                  TICK;
    logic                  WRAP;
    logic                  ZERO;

    modport master (
        output EN, UP, LOAD, LOAD_VAL,
        input  VAL, TICK, WRAP, ZERO
    );

    modport slave (
        input  EN, UP, LOAD, LOAD_VAL,
        output VAL, TICK, WRAP, ZERO
    );
endinterface

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled multi-digit up/down counter, per-digit modulus.
// Ports: CLK, RST (sync, active-high); bus (slave): EN UP LOAD LOAD_VAL / VAL TICK WRAP ZERO.
module bcd_tick_counter #(
    parameter logic [31:0] PRESCALE = 32'd1_000_000,
    parameter int          DIGITS   = 4,
    parameter logic [31:0] DIG_MOD  = 32'h0000_6A6A
) (
    input  logic              CLK,
    input  logic              RST,
    bcd_tick_counter_if.slave bus
);

    localparam logic [31:0] PS_MAX = PRESCALE - 32'd1;

    function automatic bit f_params_ok();
        logic [3:0] nib;
        if (PRESCALE == 32'd0) return 1'b0;
        if (DIGITS < 1 || DIGITS > 8) return 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = DIG_MOD[4*i +: 4];
            if (nib < 4'd2 || nib > 4'd10) return 1'b0;
        end
        return 1'b1;
    endfunction

    localparam bit PARAMS_OK = f_params_ok();

    logic [31:0]             r_psc;
    logic [DIGITS-1:0][3:0]  r_dig;
    logic [DIGITS-1:0][3:0]  w_dig_nxt;
    logic [DIGITS-1:0][3:0]  w_load;
    logic                    w_tick;

    // A step only happens on enabled, non-load, non-reset cycles.
    assign w_tick = !RST && !bus.LOAD && bus.EN && (r_psc == PS_MAX);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        localparam logic [3:0] MOD = DIG_MOD[4*g +: 4];
        localparam logic [3:0] TOP = MOD - 4'd1;

        logic       w_ci;
        logic       w_co;
        logic       w_end;
        logic [3:0] w_nxt;
        logic [3:0] w_lv;

        // Carry/borrow ripples combinationally from digit 0 upward.
        if (g == 0) begin : g_first
            assign w_ci = w_tick;
        end else begin : g_rest
            assign w_ci = g_dig[g-1].w_co;
        end

        assign w_end = bus.UP ? (r_dig[g] == TOP) : (r_dig[g] == 4'd0);
        assign w_co  = w_ci && w_end;

        assign w_nxt = !w_ci  ? r_dig[g] :
                       bus.UP ? (w_end ? 4'd0 : r_dig[g] + 4'd1) :
                                (w_end ? TOP  : r_dig[g] - 4'd1);

        assign w_lv          = bus.LOAD_VAL[4*g +: 4];
        assign w_load[g]     = (w_lv >= MOD) ? TOP : w_lv;
        assign w_dig_nxt[g]  = w_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_psc <= '0;
            r_dig <= '0;
        end else if (bus.LOAD) begin
            r_psc <= '0;
            r_dig <= w_load;
        end else if (bus.EN) begin
            r_psc <= w_tick ? 32'd0 : r_psc + 32'd1;
            r_dig <= w_dig_nxt;
        end
    end

    assign bus.VAL  = r_dig;
    assign bus.TICK = w_tick;
    assign bus.WRAP = g_dig[DIGITS-1].w_co;
    assign bus.ZERO = (r_dig == '0);

    always_ff @(posedge CLK) begin : p_param_chk
        assert (PARAMS_OK)
        else $error("bcd_tick_counter: illegal PRESCALE/DIGITS/DIG_MOD");
    end

endmodule
